mash_dsm: RTL and testbench
===========================

# mash_dsm

Parametrised MASH 1-1-…-1 delta-sigma modulator for the fractional-N PLL divider path. Order 1 to 4 is selected at elaboration. Each cycle the block accumulates a BITS-wide fractional word and emits a signed divider offset `dn`, plus the summed divide value `div = n_int + dn`. It adds synchronous reset, clock enable, a glitch-free fractional-word load, and optional LSB dither.

## Interface
- `BITS`, 8: fractional accumulator width; resolution is 1/2^BITS.
- `ORDER`, 4: number of cascaded first-order stages, legal values 1 to 4.
- `NBITS`, 8: width of the integer divide word and of `div`.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ce` input 1: clock enable; when low, all state holds.
- `f` input BITS: fractional word, sampled only when `f_load`=1.
- `f_load` input 1: capture `f` into the internal `f_q` register.
- `n_int` input NBITS: integer divide ratio, registered every enabled cycle.
- `dn` output ORDER+1, signed: modulator output.
- `div` output NBITS: `n_int_q + dn`, sign-extended, modulo 2^NBITS.

## Operation
- **Reset** (rst=1 at an edge): applies regardless of `ce`. Afterwards all of the following are 0:
  - `f_q`, `n_int_q`;
  - all stage accumulators;
  - all difference-delay registers;
  - `dn` and `div`.
  - With the dither macro defined, the LFSR is set to 15'h0001.
- **Load:**
  - At an edge with `f_load`=1, `f_q` <= `f`. This happens even when `ce`=0.
  - Stage 1 uses the new `f_q` from the next enabled cycle onward.
  - The accumulators are not cleared, so the phase stays continuous.
- **Stage k**, for k = 1 to ORDER:
  - `sum_k = acc_k + in_k` at BITS+1 bits. Carry `c_k` is `sum_k[BITS]`.
  - `acc_k` <= `sum_k[BITS-1:0]` when `ce`=1.
  - `in_1` is `f_q`. For k > 1, `in_k` is the registered `acc_{k-1}`.
- **Noise cancellation** is recursive from the top stage down:
  - `d_ORDER` <= `c_ORDER`.
  - For k < ORDER: `d_k` <= `c_k + d_{k+1} - d_{k+1}_prev`, where `d_{k+1}_prev` is `d_{k+1}` delayed by one enabled cycle.
  - `dn` is `d_1`.
  - Intermediates are computed at ORDER+2 signed bits and truncated to ORDER+1 bits; truncation is lossless.
- **Output range** of `dn`: −(2^(ORDER−1)−1) to 2^(ORDER−1). For ORDER=1 this is 0 to 1; for ORDER=4 it is −7 to 8.
- **Divide word:**
  - `div` <= `n_int_q + sext(dn)` when `ce`=1.
  - The sum wraps modulo 2^NBITS and there is no saturation.
  - `n_int_q` <= `n_int` when `ce`=1.
- **Accumulator wrap:** each `acc` wraps naturally modulo 2^BITS. Overflow is the carry and is not an error.
- **`f`=0:** `dn` stays 0 forever from reset, except when dither is enabled.

## Timing
- The `f` to `dn` first-order term takes effect one enabled cycle after `f_q` updates, so 2 edges after `f_load`.
- Stage k's contribution first reaches `dn` k enabled cycles after its carry occurs.
- `div` lags `dn` by one cycle.
- The `n_int` to `div` latency is 2 enabled cycles.
- With `ce`=0, every register except `f_q` holds and the outputs are stable.
- **Simultaneous events:**
  - `rst` and `f_load` together: `rst` wins and `f_q` becomes 0.
  - `f_load` and `ce`=1 together: the accumulators use the old `f_q` in that cycle.
- Reset in mid-sequence clears the whole pipeline in one edge. There is no partial state.

## Configuration
- **`MASH_DSM_DITHER_EN` defined:**
  - A 15-bit Fibonacci LFSR (taps 15,14) advances on each enabled cycle.
  - Its bit 0 is added to `in_1` at BITS+1 bits. Carry into bit BITS is folded into `c_1`.
  - This breaks the limit cycles at rational `f`.
- **Undefined:** no LFSR is built, `in_1` is `f_q`, and the output is exactly periodic for rational `f`.

## Structure
- Package `mash_pkg` holds:
  - `MASH_MAX_ORDER` = 4;
  - the function `mash_dn_w(order)`, which returns order+1;
  - the LFSR width, seed and taps constants.
- Sub-module `mash_stage` is the BITS-wide accumulator with carry out and `ce`/`rst`. It is instantiated ORDER times in a generate loop.
- Cancellation registers and the `div` adder live in `mash_dsm`.
- ORDER outside 1 to 4 triggers an elaboration-time `$error`.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `f`=8'hA5 loaded, then release with `f`=0. Check `dn`=0 and `div`=0 during reset and afterwards (dither off).
- **ORDER=1, BITS=8, `f`=128:** `dn` alternates 0,1 starting 2 edges after `f_load`. With `n_int`=40, `div` alternates 40,41.
- **ORDER=4, BITS=8, `f`=1:**
  - `dn` stays within −7 to 8 at all times.
  - The sum of `dn` over 256×16 cycles equals 16 ± 8.
  - The mean converges to 1/256.
- **`ce` toggling:** with `ce` low for 10 cycles, the `dn`/`div` sequence is identical to a run with `ce` high throughout, just stretched.
- **`f_load` in mid-run:** change from 64 to 192 while `ce`=1. The old value is used on the load edge and the new one afterwards. The accumulator value is not reset, which the bench checks against a bit-accurate model.
- **`div` wrap:** `n_int`=8'hFF with `dn`=+1 gives `div`=0. `n_int`=0 with `dn`=−1 gives `div`=8'hFF.

Source files
------------

// File: rtl/mash_pkg.sv
// Shared constants for the MASH 1-1-...-1 delta-sigma modulator: order limit,
// output-width helper and the dither LFSR definition (used with MASH_DSM_DITHER_EN).
package mash_pkg;

    localparam int MASH_MAX_ORDER = 4;

    localparam int          MASH_LFSR_W    = 15;
    localparam logic [14:0] MASH_LFSR_SEED = 15'h0001;
    // Fibonacci taps 15,14 -> bit positions 14 and 13
    localparam logic [14:0] MASH_LFSR_TAPS = 15'h6000;

    function automatic int mash_dn_w(input int order);
        return order + 1;
    endfunction

endpackage

// File: rtl/mash_stage.sv
// One first-order MASH stage: a BITS-wide wrapping accumulator whose carry out
// is the stage's quantised output.
module mash_stage
    import mash_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [BITS-1:0] addend,
    input  logic            cin,
    output logic [BITS-1:0] acc,
    output logic            carry
);

    logic [BITS:0] sum;

    // acc + addend + cin never exceeds 2^(BITS+1)-1, so one carry bit suffices
    assign sum   = {1'b0, acc} + {1'b0, addend} + {{BITS{1'b0}}, cin};
    assign carry = sum[BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (ce) begin
            acc <= sum[BITS-1:0];
        end
    end

endmodule

// File: rtl/mash_dsm.sv
// MASH 1-1-...-1 delta-sigma modulator for a fractional-N divider, ORDER 1..4.
// Define MASH_DSM_DITHER_EN to add a 15-bit LFSR LSB dither into stage 1.
module mash_dsm
    import mash_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int ORDER = 4,
    parameter int NBITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [BITS-1:0]    f,
    input  logic               f_load,
    input  logic [NBITS-1:0]   n_int,
    output logic signed [ORDER:0] dn,
    output logic [NBITS-1:0]   div
);

    localparam int DW = mash_dn_w(ORDER);

    if (ORDER < 1 || ORDER > MASH_MAX_ORDER) begin : g_order_check
        $error("mash_dsm: ORDER=%0d outside 1..%0d", ORDER, MASH_MAX_ORDER);
    end

    function automatic logic [DW-1:0] cancel_term(
        input logic                 carry,
        input logic signed [DW-1:0] up,
        input logic signed [DW-1:0] up_prev
    );
        logic signed [DW:0] wide;
        wide = $signed({{DW{1'b0}}, carry})
             + $signed({up[DW-1], up})
             - $signed({up_prev[DW-1], up_prev});
        return wide[DW-1:0];
    endfunction

    function automatic logic [NBITS-1:0] div_sum(
        input logic [NBITS-1:0]     base,
        input logic signed [DW-1:0] off
    );
        logic signed [NBITS-1:0] off_x;
        off_x = NBITS'(off);
        return base + off_x;
    endfunction

    logic [BITS-1:0]  f_q;
    logic [NBITS-1:0] n_int_q;
    logic             dither_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q <= '0;
        end else if (f_load) begin
            f_q <= f;
        end
    end

`ifdef MASH_DSM_DITHER_EN
    logic [MASH_LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= MASH_LFSR_SEED;
        end else if (ce) begin
            lfsr_q <= {lfsr_q[MASH_LFSR_W-2:0], ^(lfsr_q & MASH_LFSR_TAPS)};
        end
    end

    assign dither_bit = lfsr_q[0];
`else
    assign dither_bit = 1'b0;
`endif

    // p0: cascaded accumulators, stage k integrates the residue of stage k-1
    logic [ORDER-1:0][BITS-1:0] acc_p0;
    logic [ORDER-1:0]           carry_p0;
    logic [BITS-1:0]            acc_last_unused;

    for (genvar k = 0; k < ORDER; k++) begin : g_stage
        logic [BITS-1:0] addend;
        logic            cin;

        if (k == 0) begin : g_first
            assign addend = f_q;
            assign cin    = dither_bit;
        end else begin : g_next
            assign addend = acc_p0[k-1];
            assign cin    = 1'b0;
        end

        mash_stage #(
            .BITS(BITS)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .ce    (ce),
            .addend(addend),
            .cin   (cin),
            .acc   (acc_p0[k]),
            .carry (carry_p0[k])
        );
    end

    // The top stage's residue feeds nothing further down the cascade.
    assign acc_last_unused = acc_p0[ORDER-1];

    // p1/p2: recursive noise cancellation, d_p1[k] = c_k + d_{k+1} - d_{k+1} delayed
    logic [ORDER-1:0][DW-1:0] d_p1;
    logic [ORDER-1:0][DW-1:0] dly_p2;
    logic [ORDER-1:0][DW-1:0] up_w;
    logic [ORDER-1:0][DW-1:0] d_nxt;

    for (genvar k = 0; k < ORDER; k++) begin : g_cancel
        if (k == ORDER - 1) begin : g_top
            assign up_w[k] = '0;
        end else begin : g_mid
            assign up_w[k] = d_p1[k+1];
        end
        assign d_nxt[k] = cancel_term(carry_p0[k], up_w[k], dly_p2[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_p1   <= '0;
            dly_p2 <= '0;
        end else if (ce) begin
            d_p1   <= d_nxt;
            dly_p2 <= up_w;
        end
    end

    assign dn = d_p1[0];

    // Divide word: registered integer ratio plus sign-extended offset, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            n_int_q <= '0;
            div     <= '0;
        end else if (ce) begin
            n_int_q <= n_int;
            div     <= div_sum(n_int_q, dn);
        end
    end

endmodule

// File: tb/tb_mash_dsm.sv
// Self-checking bench for mash_dsm: an ORDER=4 and an ORDER=1 instance share
// stimulus and are checked against a carry-history MASH reference model.
module tb_mash_dsm;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic              f_load;
    logic [7:0]        f;
    logic [7:0]        n_int;
    logic signed [4:0] dn4;
    logic [7:0]        div4;
    logic signed [1:0] dn1;
    logic [7:0]        div1;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_fq, m_nq, m_dn4, m_dn1, m_div4, m_div1;
    int m_acc [4];
    int m_hist[4][8];

    mash_dsm #(.BITS(8), .ORDER(4), .NBITS(8)) dut4 (
        .clk(clk), .rst(rst), .ce(ce), .f(f), .f_load(f_load),
        .n_int(n_int), .dn(dn4), .div(div4)
    );

    mash_dsm #(.BITS(8), .ORDER(1), .NBITS(8)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .f(f), .f_load(f_load),
        .n_int(n_int), .dn(dn1), .div(div1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1);
    end

    function automatic int binom(input int n, input int j);
        int r;
        r = 1;
        for (int i = 0; i < j; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // dn is the sum over stages k of (1 - z^-1)^(k-1) applied to carry c_k,
    // delayed by k-1 enabled cycles beyond the first output register.
    task automatic model_step();
        int s[4];
        if (rst) begin
            m_fq = 0; m_nq = 0; m_dn4 = 0; m_dn1 = 0; m_div4 = 0; m_div1 = 0;
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0;
                for (int j = 0; j < 8; j++) m_hist[k][j] = 0;
            end
        end else begin
            if (ce) begin
                s[0] = m_acc[0] + m_fq;
                for (int k = 1; k < 4; k++) s[k] = m_acc[k] + m_acc[k-1];
                for (int k = 0; k < 4; k++) begin
                    for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                    m_hist[k][0] = s[k] / 256;
                    m_acc[k]     = s[k] % 256;
                end
                m_div4 = (m_nq + m_dn4) & 255;
                m_div1 = (m_nq + m_dn1) & 255;
                m_nq   = int'(n_int);
                m_dn1  = m_hist[0][0];
                m_dn4  = 0;
                for (int k = 1; k <= 4; k++)
                    for (int j = 0; j < k; j++)
                        m_dn4 += ((j % 2) != 0 ? -1 : 1) * binom(k - 1, j) * m_hist[k-1][k-1+j];
            end
            if (f_load) m_fq = int'(f);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; f = 8'hA5; f_load = 1'b1; n_int = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (dn4 !== 5'sd0 || div4 !== 8'd0) begin
                n_err++;
                $display("FAIL reset_o4: dn=%0d div=%0d required 0/0", dn4, div4);
            end
            n_vec++;
            if (dn1 !== 2'sd0 || div1 !== 8'd0) begin
                n_err++;
                $display("FAIL reset_o1: dn=%0d div=%0d required 0/0", dn1, div1);
            end
            ce = 1'b1;
        end
        rst = 1'b0; f_load = 1'b0; f = 8'h00; n_int = 8'h00; ce = 1'b1;
        tick();
        f_load = 1'b1;
        tick();
        f_load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (dn4 !== 5'sd0 || div4 !== 8'd0) begin
                n_err++;
                $display("FAIL post_reset_o4 cyc %0d: dn=%0d div=%0d required 0/0", i, dn4, div4);
            end
            n_vec++;
            if (dn1 !== 2'sd0 || div1 !== 8'd0) begin
                n_err++;
                $display("FAIL post_reset_o1 cyc %0d: dn=%0d div=%0d required 0/0", i, dn1, div1);
            end
        end
    endtask

    task automatic test_order1_half();
        logic signed [1:0] exp_dn;
        logic [7:0]        exp_div;
        f = 8'd128; f_load = 1'b1; n_int = 8'd40; ce = 1'b1;
        tick();
        f_load = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_dn  = (i % 2 == 0) ? 2'sd1 : 2'sd0;
            exp_div = ((i - 1) > 0 && ((i - 1) % 2 == 0)) ? 8'd41 : 8'd40;
            n_vec++;
            if (dn1 !== exp_dn) begin
                n_err++;
                $display("FAIL o1_half_dn edge %0d: dn=%0d required %0d", i, dn1, exp_dn);
            end
            n_vec++;
            if (div1 !== exp_div) begin
                n_err++;
                $display("FAIL o1_half_div edge %0d: div=%0d required %0d", i, div1, exp_div);
            end
            n_vec++;
            if (dn4 !== 5'(m_dn4) || div4 !== 8'(m_div4)) begin
                n_err++;
                $display("FAIL o1_half_o4 edge %0d: dn=%0d div=%0d required %0d/%0d", i, dn4, div4, m_dn4, m_div4);
            end
        end
    endtask

    task automatic test_order4_f1();
        int sum;
        int v;
        rst = 1'b1; ce = 1'b1; f_load = 1'b0; n_int = 8'd10;
        tick();
        rst = 1'b0; f = 8'd1; f_load = 1'b1;
        tick();
        f_load = 1'b0;
        sum = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            v = dn4;
            sum += v;
            n_vec++;
            if (dn4 !== 5'(m_dn4) || div4 !== 8'(m_div4)) begin
                n_err++;
                $display("FAIL o4_f1 cyc %0d: dn=%0d div=%0d required %0d/%0d", i, dn4, div4, m_dn4, m_div4);
            end
            n_vec++;
            if (v < -7 || v > 8) begin
                n_err++;
                $display("FAIL o4_range cyc %0d: dn=%0d required -7..8", i, v);
            end
        end
        n_vec++;
        if (sum < 8 || sum > 24) begin
            n_err++;
            $display("FAIL o4_sum: sum=%0d required 16+-8", sum);
        end
    endtask

    task automatic test_ce_toggle();
        int   ref_dn[$];
        int   ref_div[$];
        int   got;
        int   prev_dn, prev_div;
        logic [7:0] fv;
        fv = 8'($urandom_range(1, 255));
        rst = 1'b1; ce = 1'b1; f_load = 1'b0; n_int = 8'($urandom_range(0, 255));
        tick();
        rst = 1'b0; f = fv; f_load = 1'b1;
        tick();
        f_load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            ref_dn.push_back(m_dn4);
            ref_div.push_back(m_div4);
            n_vec++;
            if (dn4 !== 5'(m_dn4) || div4 !== 8'(m_div4)) begin
                n_err++;
                $display("FAIL ce_ref cyc %0d: dn=%0d div=%0d required %0d/%0d", i, dn4, div4, m_dn4, m_div4);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; f_load = 1'b1;
        tick();
        f_load = 1'b0;
        got = 0;
        prev_dn = m_dn4; prev_div = m_div4;
        for (int t = 0; t < 300 && got < 30; t++) begin
            ce = (t >= 5 && t < 15) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
            n_vec++;
            if (ce) begin
                if (dn4 !== 5'(ref_dn[got]) || div4 !== 8'(ref_div[got])) begin
                    n_err++;
                    $display("FAIL ce_stretch step %0d: dn=%0d div=%0d required %0d/%0d", got, dn4, div4, ref_dn[got], ref_div[got]);
                end
                got++;
            end else begin
                if (dn4 !== 5'(prev_dn) || div4 !== 8'(prev_div)) begin
                    n_err++;
                    $display("FAIL ce_hold t %0d: dn=%0d div=%0d required %0d/%0d", t, dn4, div4, prev_dn, prev_div);
                end
            end
            prev_dn = m_dn4; prev_div = m_div4;
        end
        ce = 1'b1;
        n_vec++;
        if (got != 30) begin
            n_err++;
            $display("FAIL ce_budget: steps=%0d required 30", got);
        end
    endtask

    task automatic test_fload_midrun();
        int pre;
        rst = 1'b1; ce = 1'b1; f_load = 1'b0; n_int = 8'($urandom_range(0, 255));
        tick();
        rst = 1'b0; f = 8'd64; f_load = 1'b1;
        tick();
        f_load = 1'b0;
        pre = $urandom_range(5, 40);
        for (int i = 0; i < pre + 41; i++) begin
            if (i == pre) begin
                f = 8'd192; f_load = 1'b1;
            end
            tick();
            f_load = 1'b0;
            n_vec++;
            if (dn4 !== 5'(m_dn4) || div4 !== 8'(m_div4) || dn1 !== 2'(m_dn1) || div1 !== 8'(m_div1)) begin
                n_err++;
                $display("FAIL fload cyc %0d: o4 %0d/%0d o1 %0d/%0d required %0d/%0d %0d/%0d",
                         i, dn4, div4, dn1, div1, m_dn4, m_div4, m_dn1, m_div1);
            end
        end
    endtask

    task automatic test_div_wrap();
        logic [7:0] exp_div;
        int pm;
        rst = 1'b1; ce = 1'b1; f_load = 1'b0;
        tick();
        rst = 1'b0; f = 8'd128; f_load = 1'b1; n_int = 8'hFF;
        tick();
        f_load = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_div = ((i - 1) > 0 && ((i - 1) % 2 == 0)) ? 8'h00 : 8'hFF;
            n_vec++;
            if (div1 !== exp_div) begin
                n_err++;
                $display("FAIL wrap_up edge %0d: div=%0d required %0d", i, div1, exp_div);
            end
        end
        rst = 1'b1; n_int = 8'h00;
        tick();
        rst = 1'b0; f = 8'($urandom_range(1, 255)); f_load = 1'b1;
        tick();
        f_load = 1'b0;
        for (int i = 0; i < 300; i++) begin
            pm = m_dn4;
            tick();
            n_vec++;
            if (div4 !== 8'(m_div4)) begin
                n_err++;
                $display("FAIL wrap_o4 cyc %0d: div=%0d required %0d", i, div4, m_div4);
            end
            if (pm == -1) begin
                n_vec++;
                if (div4 !== 8'hFF) begin
                    n_err++;
                    $display("FAIL wrap_down cyc %0d: div=%0d required 255", i, div4);
                end
            end
        end
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 99) < 2);
            ce     = ($urandom_range(0, 4) != 0);
            f_load = ($urandom_range(0, 9) == 0);
            f      = 8'($urandom_range(0, 255));
            n_int  = 8'($urandom_range(0, 255));
            tick();
            v = dn4;
            n_vec++;
            if (dn4 !== 5'(m_dn4) || div4 !== 8'(m_div4) || dn1 !== 2'(m_dn1) || div1 !== 8'(m_div1)) begin
                n_err++;
                $display("FAIL random cyc %0d: o4 %0d/%0d o1 %0d/%0d required %0d/%0d %0d/%0d",
                         i, dn4, div4, dn1, div1, m_dn4, m_div4, m_dn1, m_div1);
            end
            n_vec++;
            if (v < -7 || v > 8) begin
                n_err++;
                $display("FAIL random_range cyc %0d: dn=%0d required -7..8", i, v);
            end
        end
        rst = 1'b0; ce = 1'b1; f_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; f_load = 1'b0; f = 8'h00; n_int = 8'h00;
        test_reset();
        test_order1_half();
        test_order4_f1();
        test_ce_toggle();
        test_fload_midrun();
        test_div_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
